// File: rtl/yolo_layer_sched.sv
// Layer sequencer for a YOLO conv kernel: walks a small config table and drives one ap_ctrl kernel per layer.
// Optional stall watchdog compiled in with `define YOLO_SCHED_WDOG_EN.
module yolo_layer_sched #(
   parameter int unsigned NUM_LAYERS_MAX = 16,
   parameter int unsigned CFG_W          = 32,
   parameter int unsigned WDOG_CYCLES    = 65536
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              start,
   input  logic [4:0]        num_layers,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [CFG_W-1:0]  cfg_data,
   output logic              kern_ap_start,
   input  logic              kern_ap_ready,
   input  logic              kern_ap_done,
   output logic [CFG_W-1:0]  kern_cfg,
   input  logic              in_tvalid,
   input  logic              in_tready,
   input  logic              out_tvalid,
   input  logic              out_tready,
   output logic [3:0]        cur_layer,
   output logic [23:0]       out_beats,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   input  logic              err_clr
);

   localparam int unsigned BEAT_W = 24;
   localparam logic [4:0]  NL_MAX = 5'(NUM_LAYERS_MAX);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, RUN, NEXT, DONE, ERR
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CFG_W-1:0]    tbl [NUM_LAYERS_MAX];
   logic [4:0]          nl_q;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [4:0]          nl_clamped_c;
   logic                last_c;
   logic                idle_like_c;

   assign nl_clamped_c = (num_layers > NL_MAX) ? NL_MAX : num_layers;
   assign last_c       = ({1'b0, cur_layer} == (nl_q - 5'd1));
   assign idle_like_c  = (state == IDLE) || (state == ERR);

`ifdef YOLO_SCHED_WDOG_EN
   localparam int unsigned WDW = $clog2(WDOG_CYCLES + 1);

   logic [WDW-1:0] stall_cnt;
   logic           stall_c;
   logic           wdog_trip_c;

   assign stall_c     = !(in_tvalid && in_tready) && !(out_tvalid && out_tready);
   assign wdog_trip_c = (state == RUN) && stall_c && (stall_cnt == WDW'(WDOG_CYCLES - 1));

   // Stall counter only runs while a kernel is executing; any handshake rearms it
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         stall_cnt <= '0;
      end else if ((state == RUN) && stall_c) begin
         stall_cnt <= stall_cnt + WDW'(1);
      end else begin
         stall_cnt <= '0;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         err      <= 1'b0;
         err_code <= 2'd0;
      end else begin
         err <= (state_nxt == ERR);
         if (wdog_trip_c && (state_nxt == ERR)) begin
            err_code <= {~out_tready, ~in_tvalid};
         end else if (state_nxt != ERR) begin
            err_code <= 2'd0;
         end
      end
   end
`else
   logic unused_wdog;
   assign unused_wdog = ^{err_clr, in_tvalid, in_tready, 32'(WDOG_CYCLES)};
   assign err         = 1'b0;
   assign err_code    = 2'd0;
`endif

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (num_layers == 5'd0) ? DONE : LOAD;
         LOAD:  state_nxt = START;
         START: if (kern_ap_ready) state_nxt = kern_ap_done ? NEXT : RUN;
         RUN: begin
            if (kern_ap_done) begin
               state_nxt = NEXT;
`ifdef YOLO_SCHED_WDOG_EN
            end else if (wdog_trip_c) begin
               state_nxt = ERR;
`endif
            end
         end
         NEXT:  state_nxt = last_c ? DONE : LOAD;
         DONE:  state_nxt = IDLE;
         ERR: begin
`ifdef YOLO_SCHED_WDOG_EN
            if (err_clr) state_nxt = IDLE;
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Layer table is writable only while no sequence is active
   always_ff @(posedge ap_clk) begin
      if (cfg_we && idle_like_c && (32'(cfg_addr) < NUM_LAYERS_MAX)) begin
         tbl[cfg_addr] <= cfg_data;
      end
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         kern_ap_start <= 1'b0;
         kern_cfg      <= '0;
         cur_layer     <= 4'd0;
         out_beats     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         nl_q          <= 5'd0;
         beat_cnt      <= '0;
      end else begin
         kern_ap_start <= (state_nxt == START);
         busy          <= (state_nxt != IDLE) && (state_nxt != ERR);
         done          <= (state_nxt == DONE);

         if ((state == IDLE) && start) begin
            cur_layer <= 4'd0;
            nl_q      <= nl_clamped_c;
         end

         if (state == LOAD) begin
            kern_cfg <= tbl[cur_layer];
         end

         if (state == NEXT) begin
            out_beats <= beat_cnt;
            if (!last_c) cur_layer <= cur_layer + 4'd1;
         end

         // Output beat counter, saturating
         if (state == LOAD) begin
            beat_cnt <= '0;
         end else if (((state == START) || (state == RUN)) && out_tvalid && out_tready
                      && (beat_cnt != {BEAT_W{1'b1}})) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_yolo_layer_sched.sv
// Scoreboard bench for yolo_layer_sched: expected kern_cfg words and out_beats are queued by the
// stimulus thread and checked by a monitor on kern_ap_start rising edges and done pulses.
module tb_yolo_layer_sched;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        start;
   logic [4:0]  num_layers;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        kern_ap_start;
   logic        kern_ap_ready;
   logic        kern_ap_done;
   logic [31:0] kern_cfg;
   logic        in_tvalid, in_tready, out_tvalid, out_tready;
   logic [3:0]  cur_layer;
   logic [23:0] out_beats;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic        err_clr;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] cfg_q   [$];
   logic [23:0] beats_q [$];
   logic [23:0] last_beats = '0;
   logic        kstart_prev = 1'b0;

   yolo_layer_sched #(.NUM_LAYERS_MAX(16), .CFG_W(32), .WDOG_CYCLES(16)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .num_layers(num_layers),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .kern_ap_start(kern_ap_start), .kern_ap_ready(kern_ap_ready), .kern_ap_done(kern_ap_done),
      .kern_cfg(kern_cfg), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .cur_layer(cur_layer),
      .out_beats(out_beats), .busy(busy), .done(done), .err(err), .err_code(err_code),
      .err_clr(err_clr)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   // Pulse start and measure edges until kern_ap_start appears
   task automatic start_seq(input logic [4:0] n);
      int lat;
      num_layers = n;
      start = 1'b1;
      lat = 0;
      do begin
         tick();
         start = 1'b0;
         lat++;
      end while (!kern_ap_start && lat < 10);
      chk("start_to_kstart", 64'(lat), 64'd2);
   endtask

   task automatic kernel_layer(input int idx, input int d, input int beats,
                               input bit last, input bit inject);
      int n;
      int kcnt;
      n = 0;
      while (!kern_ap_start && n < 50) begin tick(); n++; end
      chk("kstart_seen", 64'(kern_ap_start), 64'd1);
      if (!kern_ap_start) return;
      chk("cur_layer", 64'(cur_layer), 64'(idx));
      kcnt = 0;
      while (kern_ap_start && kcnt < 100) begin
         kcnt++;
         kern_ap_ready = (kcnt > d);
         tick();
      end
      kern_ap_ready = 1'b0;
      chk("kstart_width", 64'(kcnt), 64'(d + 1));
      if (inject) begin
         start = 1'b1; num_layers = 5'd5;
         cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 32'hBEEF;
         tick();
         start = 1'b0; cfg_we = 1'b0;
      end
      for (int i = 0; i < beats; i++) begin
         out_tvalid = 1'b1;
         tick();
      end
      out_tvalid = 1'b0;
      kern_ap_done = 1'b1;
      if (!last) begin
         n = 0;
         do begin
            tick();
            kern_ap_done = 1'b0;
            n++;
         end while (!kern_ap_start && n < 10);
         chk("done_to_kstart", 64'(n), 64'd3);
      end else begin
         tick();
         kern_ap_done = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      chk("idle_reached", 64'(busy), 64'd0);
      tick();
   endtask

   task automatic monitor_step();
      if (ap_rst) begin
         kstart_prev = 1'b0;
         return;
      end
      if (kern_ap_start && !kstart_prev) begin
         if (cfg_q.size() == 0) begin
            chk("unexpected_kstart", 64'(kern_ap_start), 64'd0);
         end else begin
            chk("kern_cfg", 64'(kern_cfg), 64'(cfg_q.pop_front()));
         end
      end
      kstart_prev = kern_ap_start;
      if (done) begin
         if (beats_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            chk("out_beats", 64'(out_beats), 64'(beats_q.pop_front()));
         end
      end
   endtask

   task automatic main_seq();
      int n;
      ap_rst = 1'b1; start = 1'b0; num_layers = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      kern_ap_ready = 1'b0; kern_ap_done = 1'b0; err_clr = 1'b0;
      in_tvalid = 1'b1; in_tready = 1'b1; out_tvalid = 1'b0; out_tready = 1'b1;
      repeat (3) tick();
      chk("rst_kstart", 64'(kern_ap_start), 64'd0);
      chk("rst_kcfg", 64'(kern_cfg), 64'd0);
      chk("rst_cur_layer", 64'(cur_layer), 64'd0);
      chk("rst_out_beats", 64'(out_beats), 64'd0);
      chk("rst_busy_done", 64'({busy, done}), 64'd0);
      chk("rst_err", 64'({err, err_code}), 64'd0);
      ap_rst = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) cfg_write(4'(i), 32'hA0 + 32'(i));

      // Three layers, five beats each; layer 1 kernel stalls ready for 7 cycles
      cfg_q.push_back(32'hA0); cfg_q.push_back(32'hA1); cfg_q.push_back(32'hA2);
      beats_q.push_back(24'd5); last_beats = 24'd5;
      start_seq(5'd3);
      chk("busy_running", 64'(busy), 64'd1);
      for (int l = 0; l < 3; l++) kernel_layer(l, (l == 1) ? 7 : 0, 5, l == 2, 1'b0);
      wait_idle();

      // Zero layers: immediate done, no kernel start
      beats_q.push_back(last_beats);
      num_layers = 5'd0;
      start = 1'b1;
      n = 0;
      do begin tick(); start = 1'b0; n++; end while (!done && n < 10);
      chk("zero_done_lat", 64'(n), 64'd1);
      tick();
      chk("zero_done_width", 64'(done), 64'd0);
      wait_idle();

      // Start and table write during RUN are ignored
      cfg_q.push_back(32'hA0);
      beats_q.push_back(24'd2); last_beats = 24'd2;
      start_seq(5'd1);
      kernel_layer(0, 0, 2, 1'b1, 1'b1);
      wait_idle();
      cfg_q.push_back(32'hA0); cfg_q.push_back(32'hA1);
      beats_q.push_back(24'd3); last_beats = 24'd3;
      start_seq(5'd2);
      kernel_layer(0, 2, 1, 1'b0, 1'b0);
      kernel_layer(1, 0, 3, 1'b1, 1'b0);
      wait_idle();

      // num_layers above the table depth is clamped to 16
      for (int i = 0; i < 16; i++) cfg_q.push_back(32'hA0 + 32'(i));
      beats_q.push_back(24'd1); last_beats = 24'd1;
      start_seq(5'd20);
      for (int l = 0; l < 16; l++) kernel_layer(l, 0, 1, l == 15, 1'b0);
      wait_idle();

      // Stall both streams' handshakes during RUN
      cfg_q.push_back(32'hA0);
      start_seq(5'd1);
      kern_ap_ready = 1'b1;
      tick();
      kern_ap_ready = 1'b0;
      in_tvalid = 1'b0;
`ifdef YOLO_SCHED_WDOG_EN
      n = 0;
      do begin tick(); n++; end while (!err && n < 40);
      chk("wdog_cycles", 64'(n), 64'd16);
      chk("wdog_err_code", 64'(err_code), 64'd1);
      chk("wdog_busy", 64'({busy, kern_ap_start}), 64'd0);
      in_tvalid = 1'b1;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("wdog_cleared", 64'({err, err_code, busy}), 64'd0);
      tick();
`else
      repeat (20) tick();
      chk("no_wdog_err", 64'({err, err_code}), 64'd0);
      chk("no_wdog_busy", 64'(busy), 64'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("no_wdog_clr", 64'({err, err_code, busy}), 64'b001);
      in_tvalid = 1'b1;
      beats_q.push_back(24'd0); last_beats = 24'd0;
      kern_ap_done = 1'b1;
      tick();
      kern_ap_done = 1'b0;
      wait_idle();
`endif

      // Reset during RUN of layer 1 abandons the sequence
      cfg_q.push_back(32'hA0); cfg_q.push_back(32'hA1);
      start_seq(5'd3);
      kernel_layer(0, 0, 2, 1'b0, 1'b0);
      kern_ap_ready = 1'b1;
      tick();
      kern_ap_ready = 1'b0;
      out_tvalid = 1'b1;
      repeat (2) tick();
      out_tvalid = 1'b0;
      ap_rst = 1'b1;
      #1;
      chk("midrst_kstart_cfg", 64'({kern_ap_start, kern_cfg}), 64'd0);
      chk("midrst_layer_beats", 64'({cur_layer, out_beats}), 64'd0);
      chk("midrst_flags", 64'({busy, done, err, err_code}), 64'd0);
      repeat (2) tick();
      ap_rst = 1'b0;
      repeat (5) tick();
      chk("midrst_idle", 64'(busy), 64'd0);

      chk("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
      chk("beats_q_drained", 64'(beats_q.size()), 64'd0);
   endtask

   initial begin
      fork
         begin
            forever begin
               @(negedge ap_clk);
               monitor_step();
            end
         end
         begin
            main_seq();
         end
         begin
            #200000;
            chk("global_timeout", 64'd1, 64'd0);
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/yolo_layer_sched.md
YOLO_LAYER_SCHED -- requirements
Module: yolo_layer_sched

Interface
REQ-001 SHALL have parameter NUM_LAYERS_MAX, default 16, meaning the depth of the layer table.
REQ-002 SHALL have parameter CFG_W, default 32, meaning the width of a layer config word.
REQ-003 SHALL have parameter WDOG_CYCLES, default 65536, meaning the stall cycles tolerated before a timeout.
REQ-004 ap_clk  in  1  single clock; all state on rising edge.
REQ-005 ap_rst  in  1  reset; asynchronous, active-high.
REQ-006 start  in  1  pulse; begin a layer sequence.
REQ-007 num_layers  in  5  layers to run; sampled on accepted start.
REQ-008 cfg_we / cfg_addr / cfg_data  in  1 / 4 / CFG_W  layer table write port.
REQ-009 kern_ap_start  out  1  conv kernel start.
REQ-010 kern_ap_ready / kern_ap_done  in  1 / 1  conv kernel handshake.
REQ-011 kern_cfg  out  CFG_W  config word of the current layer.
REQ-012 in_tvalid, in_tready, out_tvalid, out_tready  in  1 each  stream observation only.
REQ-013 cur_layer  out  4  index of the layer in progress.
REQ-014 out_beats  out  24  output beats counted in the last completed layer.
REQ-015 busy / done  out  1 / 1  sequence active / one-cycle completion pulse.
REQ-016 err / err_code / err_clr  out / out / in  1 / 2 / 1  timeout flag, cause, clear.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, START, RUN, NEXT, DONE, ERR.
REQ-018 IDLE SHALL accept start only; start with num_layers==0 SHALL go to DONE; otherwise LOAD with cur_layer=0.
REQ-019 LOAD SHALL register table[cur_layer] onto kern_cfg (1 cycle), then go to START.
REQ-020 START SHALL hold kern_ap_start=1 until kern_ap_ready=1 is sampled, then go to RUN and deassert kern_ap_start the next cycle.
REQ-021 kern_ap_ready and kern_ap_done high together in START SHALL go directly to NEXT.
REQ-022 RUN SHALL exit to NEXT on kern_ap_done=1.
REQ-023 NEXT SHALL latch the beat counter into out_beats; if cur_layer==num_layers-1 go to DONE, else increment cur_layer and go to LOAD.
REQ-024 DONE SHALL pulse done for exactly one cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE and ERR.
REQ-026 The beat counter SHALL clear in LOAD and increment on each out_tvalid&out_tready cycle in START/RUN, saturating at 2^24-1.
REQ-027 start while busy SHALL be ignored; cfg_we while busy SHALL be ignored, freezing the table.
REQ-028 num_layers > NUM_LAYERS_MAX SHALL be clamped to NUM_LAYERS_MAX.
REQ-029 Latency: start to first kern_ap_start SHALL be 2 cycles; kern_ap_done to next-layer kern_ap_start SHALL be 3 cycles.

Reset
REQ-030 ap_rst SHALL immediately force IDLE, kern_ap_start=0, kern_cfg=0, cur_layer=0, out_beats=0, busy=0, done=0, err=0, err_code=0; table contents are undefined after reset.
REQ-031 Reset mid-sequence SHALL abandon the sequence; no done pulse is produced.

Configuration
REQ-032 When YOLO_SCHED_WDOG_EN is defined, a stall counter SHALL increment in RUN on cycles with neither an input nor an output handshake, and clear on any handshake.
REQ-033 With the watchdog compiled in, reaching WDOG_CYCLES SHALL enter ERR and set err=1 with err_code: 1 = in_tvalid low (input starved), 2 = out_tready low (output backpressure), 3 = both; kern_ap_start SHALL be held 0 in ERR.
REQ-034 With the watchdog compiled in, err_clr in ERR SHALL return the FSM to IDLE and clear err/err_code.
REQ-035 Without YOLO_SCHED_WDOG_EN, no stall counter SHALL exist, ERR is unreachable, err and err_code SHALL be tied 0, and err_clr SHALL be ignored.

Verification
REQ-036 Write table[0..2]=0xA0,0xA1,0xA2; start with num_layers=3; kernel done after 5 out beats each -> kern_cfg sequence A0,A1,A2; out_beats=5; one done pulse.
REQ-037 start with num_layers=0 -> done pulses 1 cycle later; kern_ap_start never asserted.
REQ-038 Kernel holds ready low for 7 cycles -> kern_ap_start stays high for 8 cycles, then drops.
REQ-039 Start pulsed again and cfg_we to address 1 during RUN -> both ignored; table[1] unchanged on the next run.
REQ-040 WDOG_EN with WDOG_CYCLES=16: in RUN hold in_tvalid=0 and out_tready=1 -> err=1, err_code=1 after 16 idle cycles; err_clr -> IDLE.
REQ-041 Assert ap_rst during RUN of layer 1 -> all outputs take reset values the same cycle; no done pulse.
